// File: rtl/alu_pkg.sv
// Shared opcodes, instruction field layout and sequencer state encoding for
// the ALU issue/writeback stage.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_SRA1 = 4'b1001;
    localparam logic [3:0] OP_ROL1 = 4'b1010;
    localparam logic [3:0] OP_ROR1 = 4'b1011;
    localparam logic [3:0] OP_EQ   = 4'b1100;

    localparam int INST_W   = 16;
    localparam int CTRL_LSB = 12;
    localparam int RD_LSB   = 9;
    localparam int RS_LSB   = 6;
    localparam int RT_LSB   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Only ADD and SUB produce a meaningful ALU carry.
    function automatic logic is_arith(input logic [3:0] ctrl);
        return (ctrl == OP_ADD) || (ctrl == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_wb_if.sv
// Instruction handshake between the upstream issuer and the ALU issue/writeback stage.
interface alu_issue_wb_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;

    modport master (output in_valid, output in_inst, input  in_ready);
    modport slave  (input  in_valid, input  in_inst, output in_ready);

endinterface

// File: rtl/regfile_8x8.sv
// Register file: two combinational operand reads, one debug read and one
// synchronous write port, cleared by synchronous reset.
module regfile_8x8 #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] rs_addr,
    output logic [DW-1:0] rs_data,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rt_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem [NREG];

    // NOTE: every entry is cleared on reset because software relies on all
    // registers reading zero afterwards; this keeps the array out of RAM macros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rs_data  = mem[rs_addr];
    assign rt_data  = mem[rt_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Operand-issue and writeback stage around an external combinational 8-bit ALU:
// IDLE accepts one instruction, EXEC captures the ALU result, WB writes it back.
module alu_issue_wb #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_issue_wb_if.slave  issue,
    input  logic           ld_en,
    input  logic [AW-1:0]  ld_addr,
    input  logic [DW-1:0]  ld_data,
    input  logic [AW-1:0]  dbg_addr,
    output logic [DW-1:0]  dbg_data,
    output logic [3:0]     alu_ctrl,
    output logic [DW-1:0]  alu_x,
    output logic [DW-1:0]  alu_y,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_carry,
    output logic           carry_flag,
    output logic           wb_done
);
    import alu_pkg::*;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] res_q;

    logic          accept;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rs_data, rt_data;

    logic [3:0]    inst_ctrl;
    logic [AW-1:0] inst_rd, inst_rs, inst_rt;
    logic          unused_inst_bits;

    assign inst_ctrl        = issue.in_inst[CTRL_LSB +: 4];
    assign inst_rd          = issue.in_inst[RD_LSB +: AW];
    assign inst_rs          = issue.in_inst[RS_LSB +: AW];
    assign inst_rt          = issue.in_inst[RT_LSB +: AW];
    assign unused_inst_bits = ^issue.in_inst[RT_LSB-1:0];

    regfile_8x8 #(.NREG(NREG), .AW(AW), .DW(DW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .rs_addr  (inst_rs),
        .rs_data  (rs_data),
        .rt_addr  (inst_rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: each output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        issue.in_ready = 1'b0;
        accept         = 1'b0;
        rf_we          = 1'b0;
        rf_waddr       = ld_addr;
        rf_wdata       = ld_data;
        case (state_q)
            IDLE: begin
                issue.in_ready = !ld_en;
                accept         = issue.in_valid && !ld_en;
                rf_we          = ld_en;
            end
            WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = res_q;
            end
            default: ;
        endcase
    end

    // Operand issue, result capture and the sticky carry; a reset mid-flight
    // clears everything, so the abandoned instruction never reaches WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl   <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            rd_q       <= '0;
            res_q      <= '0;
            carry_flag <= 1'b0;
            wb_done    <= 1'b0;
        end else begin
            if (accept) begin
                alu_ctrl <= inst_ctrl;
                alu_x    <= rs_data;
                alu_y    <= rt_data;
                rd_q     <= inst_rd;
            end
            if (state_q == EXEC) begin
                res_q <= alu_out;
                if (is_arith(alu_ctrl)) carry_flag <= alu_carry;
            end
            wb_done <= (state_d == WB);
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Self-checking bench for alu_issue_wb: a behavioural ALU drives the DUT's ALU
// port and an array-based register model predicts every architectural result.
module tb_alu_issue_wb;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x, alu_y, alu_out;
    logic       alu_carry;
    logic       carry_flag;
    logic       wb_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_reg [8];
    logic       m_carry;

    alu_issue_wb_if bus ();

    alu_issue_wb dut (
        .clk        (clk),
        .rst        (rst),
        .issue      (bus),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .alu_ctrl   (alu_ctrl),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .carry_flag (carry_flag),
        .wb_done    (wb_done)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {carry, out}. Non-arithmetic ops emit a junk carry
    // so that a stage wrongly updating the sticky flag gets noticed.
    function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        int         s;
        logic [7:0] o;
        logic       cy;
        cy = x[0] ^ y[7];
        o  = 8'h00;
        case (c)
            4'd0:  begin s = int'(x) + int'(y); o = 8'(s); cy = (s > 255); end
            4'd1:  begin o = 8'(int'(x) - int'(y)); cy = (x < y); end
            4'd2:  o = x & y;
            4'd3:  o = x | y;
            4'd4:  o = ~x;
            4'd5:  o = x ^ y;
            4'd6:  o = ~(x | y);
            4'd7:  o = y << x[2:0];
            4'd8:  o = y >> x[2:0];
            4'd9:  o = {x[7], x[7:1]};
            4'd10: o = {x[6:0], x[7]};
            4'd11: o = {x[0], x[7:1]};
            4'd12: o = (x == y) ? 8'h01 : 8'h00;
            default: o = 8'h00;
        endcase
        return {cy, o};
    endfunction

    always_comb {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        check(tag, {8'h00, dbg_data}, {8'h00, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_carry = 1'b0;
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en    = 1'b0;
        m_reg[a] = d;
    endtask

    // One instruction from handshake to writeback. With noise set, ld_en is
    // toggled during EXEC/WB, where the stage must ignore it.
    task automatic issue(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input bit noise);
        logic [8:0] r;
        logic [7:0] x, y;
        int         waited;
        bus.in_inst  = {c, rd, rs, rt, 3'($urandom)};
        bus.in_valid = 1'b1;
        #1;
        check("ready_at_issue", {15'd0, bus.in_ready}, 16'd1);
        waited = 0;
        while (!bus.in_ready && waited < 8) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", {15'd0, bus.in_ready}, 16'd1);
            bus.in_valid = 1'b0;
            return;
        end
        x = m_reg[rs];
        y = m_reg[rt];
        r = alu_fn(c, x, y);
        tick();
        bus.in_valid = 1'b0;
        bus.in_inst  = 16'($urandom);
        check("alu_ctrl", {12'd0, alu_ctrl}, {12'd0, c});
        check("alu_x", {8'd0, alu_x}, {8'd0, x});
        check("alu_y", {8'd0, alu_y}, {8'd0, y});
        check("ready_exec", {15'd0, bus.in_ready}, 16'd0);
        check("wb_done_exec", {15'd0, wb_done}, 16'd0);
        if (noise) begin
            ld_en   = 1'b1;
            ld_addr = 3'($urandom);
            ld_data = 8'($urandom);
        end
        tick();
        check("wb_done_wb", {15'd0, wb_done}, 16'd1);
        check("ready_wb", {15'd0, bus.in_ready}, 16'd0);
        tick();
        ld_en = 1'b0;
        check("wb_done_after", {15'd0, wb_done}, 16'd0);
        m_reg[rd] = r[7:0];
        if (c == 4'd0 || c == 4'd1) m_carry = r[8];
        check_reg("result", rd, m_reg[rd]);
        check("carry_flag", {15'd0, carry_flag}, {15'd0, m_carry});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        ld_en        = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        dbg_addr     = '0;
        bus.in_valid = 1'b0;
        bus.in_inst  = '0;
        #3;

        // Reset state
        do_reset();
        check("rst_ready", {15'd0, bus.in_ready}, 16'd1);
        check("rst_carry", {15'd0, carry_flag}, 16'd0);
        check("rst_wb_done", {15'd0, wb_done}, 16'd0);
        check("rst_alu_ctrl", {12'd0, alu_ctrl}, 16'd0);
        for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 8'h00);

        // ADD without carry
        load(3'd1, 8'd100);
        load(3'd2, 8'd50);
        issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0);
        check_reg("add_r3", 3'd3, 8'h96);
        check("add_carry", {15'd0, carry_flag}, 16'd0);

        // ADD with carry, then AND must leave carry alone
        load(3'd1, 8'h9C);
        load(3'd2, 8'hCE);
        issue(4'd0, 3'd4, 3'd1, 3'd2, 1'b0);
        check_reg("add_r4", 3'd4, 8'h6A);
        check("add_carry1", {15'd0, carry_flag}, 16'd1);
        issue(4'd2, 3'd5, 3'd1, 3'd2, 1'b0);
        check_reg("and_r5", 3'd5, 8'h8C);
        check("and_carry_hold", {15'd0, carry_flag}, 16'd1);

        // SUB with and without borrow
        load(3'd1, 8'd5);
        load(3'd2, 8'd7);
        issue(4'd1, 3'd6, 3'd1, 3'd2, 1'b0);
        check_reg("sub_r6a", 3'd6, 8'hFE);
        check("sub_borrow", {15'd0, carry_flag}, 16'd1);
        issue(4'd1, 3'd6, 3'd2, 3'd1, 1'b0);
        check_reg("sub_r6b", 3'd6, 8'h02);
        check("sub_noborrow", {15'd0, carry_flag}, 16'd0);
        issue(4'd5, 3'd7, 3'd1, 3'd1, 1'b0);
        check("xor_carry_hold0", {15'd0, carry_flag}, 16'd0);

        // SHL into a source register, then dependent EQ back-to-back
        load(3'd1, 8'd3);
        load(3'd2, 8'h81);
        issue(4'd7, 3'd1, 3'd1, 3'd2, 1'b0);
        check_reg("shl_r1", 3'd1, 8'h08);
        issue(4'd12, 3'd0, 3'd1, 3'd1, 1'b0);
        check_reg("eq_r0", 3'd0, 8'h01);

        // Reserved opcode writes zero
        issue(4'd14, 3'd2, 3'd1, 3'd2, 1'b0);
        check_reg("rsvd_r2", 3'd2, 8'h00);

        // ld_en blocks acceptance while in_valid is held
        bus.in_valid = 1'b1;
        bus.in_inst  = {4'd0, 3'd7, 3'd1, 3'd1, 3'd0};
        ld_en        = 1'b1;
        ld_addr      = 3'd7;
        ld_data      = 8'h5A;
        #1;
        check("ld_blocks_ready", {15'd0, bus.in_ready}, 16'd0);
        tick();
        ld_en        = 1'b0;
        bus.in_valid = 1'b0;
        m_reg[7]     = 8'h5A;
        #1;
        check("ld_not_accepted", {15'd0, bus.in_ready}, 16'd1);
        check_reg("ld_r7", 3'd7, 8'h5A);
        tick();
        check("ld_no_wb", {15'd0, wb_done}, 16'd0);
        check_reg("ld_r7_kept", 3'd7, 8'h5A);

        // Reset during EXEC abandons the instruction
        bus.in_valid = 1'b1;
        bus.in_inst  = {4'd0, 3'd6, 3'd7, 3'd7, 3'd0};
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_carry = 1'b0;
        check("rst_exec_wb_done", {15'd0, wb_done}, 16'd0);
        check("rst_exec_ready", {15'd0, bus.in_ready}, 16'd1);
        check("rst_exec_alu_x", {8'd0, alu_x}, 16'd0);
        tick();
        check("rst_exec_no_wb", {15'd0, wb_done}, 16'd0);
        for (int i = 0; i < 8; i++) check_reg("rst_exec_reg", 3'(i), 8'h00);

        // Randomized traffic with stray debug loads outside IDLE
        for (int i = 0; i < 8; i++) load(3'(i), 8'($urandom));
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) load(3'($urandom), 8'($urandom));
            issue(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 8; i++) check_reg("final_reg", 3'(i), m_reg[i]);
        check("final_carry", {15'd0, carry_flag}, {15'd0, m_carry});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
